route_requester: RTL
====================

ROUTE_REQUESTER -- requirements
Module: route_requester

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- FLIT_W, 32, flit width
- ADDR_W, 2, width of each destination coordinate field
- LOCAL_X, 0, router X coordinate
- LOCAL_Y, 0, router Y coordinate
- DEPTH, 4, input buffer entries (power of two, >=2)
- STARVE_LIMIT, 16, watchdog threshold in cycles
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- in_valid  in  1  upstream flit write strobe
- in_flit  in  FLIT_W  upstream flit; dst_x=[FLIT_W-1 -: ADDR_W], dst_y=next ADDR_W bits below
- credit_out  out  1  one-cycle pulse per freed buffer slot
- request_bundle  out  3  {hit_x, hit_y, request} to arbiter
- grant  in  1  arbiter acceptance of current request
- out_flit  out  FLIT_W  buffer head flit, valid while request_bundle[0]=1
- overflow  out  1  sticky: write attempted while full and no pop
- starve  out  1  sticky: watchdog expired

Function
REQ-004 Buffer SHALL be a DEPTH-entry FIFO; push when in_valid=1; pop on an edge where request_bundle[0]=1 and grant=1.
REQ-005 Push while full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case push SHALL succeed and count SHALL be unchanged.
REQ-006 Push into empty FIFO with simultaneous pop SHALL be impossible (pop requires a registered request), so count SHALL increment.
REQ-007 Route SHALL compute hit_x=(dst_x==LOCAL_X), hit_y=(dst_y==LOCAL_Y) from the FIFO head.
- Encodings: 011 west, 101 south, 111 PE, 000 null.
- 001 (neither hit) SHALL be emitted unchanged; the arbiter resolves it X-first.
REQ-008 The FSM SHALL have two states, IDLE and REQUEST; request_bundle SHALL be registered.
REQ-009 IDLE: if FIFO non-empty, the route SHALL be latched into request_bundle with request=1 and the FSM SHALL enter REQUEST.
REQ-010 REQUEST: request_bundle SHALL stay constant until an edge with grant=1.
REQ-011 On that grant edge, pop SHALL occur and credit_out SHALL pulse next cycle.
- If count>1 before the pop, the FSM SHALL stay in REQUEST with the next head's route, giving back-to-back grants.
- Otherwise the FSM SHALL return to IDLE with request_bundle=000.
REQ-012 Latency: flit written at edge N SHALL produce request=1 from N+2 when the FIFO was empty and idle.
REQ-013 grant while request=0 SHALL be ignored.
REQ-014 Pointers SHALL wrap modulo DEPTH; count SHALL be ADDR-independent, width clog2(DEPTH)+1.

Reset
REQ-015 Reset SHALL clear the FIFO, pointers and count, set state=IDLE and request_bundle=000, and drive credit_out, overflow and starve to 0; out_flit is don't-care.
REQ-016 Reset asserted mid-REQUEST SHALL discard the buffered flits and ignore the concurrent grant; no credit_out SHALL issue for discarded flits.

Configuration
REQ-017 With REQUESTER_STARVE_MON_EN defined, a counter SHALL increment each cycle in REQUEST with grant=0.
- The counter SHALL clear on grant or IDLE.
- starve SHALL set sticky when the counter reaches STARVE_LIMIT.
REQ-018 Without REQUESTER_STARVE_MON_EN, the counter SHALL be absent and starve SHALL be tied 0.

Structure
REQ-019 Shared package atto_noc_pkg SHALL hold the request-bundle bit indices, the WEST/SOUTH/PE/NULL encodings and the flit destination field offsets.
REQ-020 The FIFO SHALL be a sub-module named flit_fifo; the route and FSM logic SHALL stay in route_requester.

Verification (LOCAL_X=1, LOCAL_Y=1, ADDR_W=2, DEPTH=4)
REQ-021 Push flit dst(0,1), grant held 0 -> request_bundle=011 from edge 2, stable for 10 cycles; grant=1 -> pop, credit_out pulse, request 000.
REQ-022 Push dst(1,0), dst(1,1) back-to-back, grant=1 constant -> request_bundle 101 then 111 on consecutive cycles, two credit_out pulses, then 000.
REQ-023 Push 5 flits with grant=0 -> 4 accepted, overflow=1; 5th push coincident with a grant -> accepted, overflow stays 0.
REQ-024 Reset asserted while in REQUEST with grant=1 -> next cycle request_bundle=000, count=0, no credit_out.
REQ-025 Macro defined, STARVE_LIMIT=16, grant=0 for 16 cycles in REQUEST -> starve=1 and stays 1 after a later grant; macro undefined -> starve=0.
REQ-026 Push dst(2,3) -> request_bundle=001 held until grant.

Source files
------------

// File: rtl/atto_noc_pkg.sv
// Shared NoC definitions: request-bundle bit positions, route encodings and
// flit destination field offsets.
package atto_noc_pkg;

  typedef logic [2:0] req_bundle_t;

  localparam int REQ_BIT   = 0;
  localparam int HIT_Y_BIT = 1;
  localparam int HIT_X_BIT = 2;

  localparam req_bundle_t RB_NULL  = 3'b000;
  localparam req_bundle_t RB_WEST  = 3'b011;
  localparam req_bundle_t RB_SOUTH = 3'b101;
  localparam req_bundle_t RB_PE    = 3'b111;

  // dst_x sits in the top ADDR_W bits of a flit, dst_y directly below it
  function automatic int dst_x_lsb(input int flit_w, input int addr_w);
    return flit_w - addr_w;
  endfunction

  function automatic int dst_y_lsb(input int flit_w, input int addr_w);
    return flit_w - 2 * addr_w;
  endfunction

  function automatic req_bundle_t make_request(input logic hit_x, input logic hit_y);
    req_bundle_t rb;
    rb            = RB_NULL;
    rb[HIT_X_BIT] = hit_x;
    rb[HIT_Y_BIT] = hit_y;
    rb[REQ_BIT]   = 1'b1;
    return rb;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Power-of-two input flit buffer; a push into a full buffer is dropped unless
// a pop happens in the same cycle.
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int HDR_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [FLIT_W-1:0]           push_flit,
  input  logic                        pop,
  output logic [FLIT_W-1:0]           head_flit,
  output logic [HDR_W-1:0]            next_hdr,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        push_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              push_ok;
  logic [FLIT_W-1:0] next_flit;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign head_flit = mem_q[rd_ptr_q];
  assign next_flit = mem_q[rd_ptr_q + PTR_W'(1)];
  assign next_hdr  = next_flit[FLIT_W-1 -: HDR_W];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_flit;
  end

endmodule

// File: rtl/route_requester.sv
// Buffers incoming flits, computes the XY route of the head flit and holds a
// registered request to the output arbiter. Optional watchdog: REQUESTER_STARVE_MON_EN.
//
// state      | meaning
// IDLE       | no request outstanding, waiting for a buffered flit
// REQUEST    | request_bundle holds the head flit's route until granted
module route_requester
  import atto_noc_pkg::*;
#(
  parameter int FLIT_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int LOCAL_X      = 0,
  parameter int LOCAL_Y      = 0,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              credit_out,
  output logic [2:0]        request_bundle,
  input  logic              grant,
  output logic [FLIT_W-1:0] out_flit,
  output logic              overflow,
  output logic              starve
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int HDR_W = 2 * ADDR_W;
  localparam int HDR_LSB = dst_y_lsb(FLIT_W, ADDR_W);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_REQUEST = 1'b1;

  logic [0:0]        state_q, state_d;
  req_bundle_t       bundle_q, bundle_d;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic [FLIT_W-1:0] head_flit;
  logic [HDR_W-1:0]  next_hdr;
  logic [CNT_W-1:0]  count;
  logic              push_drop;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .HDR_W  (HDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_flit (in_flit),
    .pop       (pop),
    .head_flit (head_flit),
    .next_hdr  (next_hdr),
    .count     (count),
    .push_drop (push_drop)
  );

  // hdr = {dst_x, dst_y}
  function automatic req_bundle_t route_of(input logic [HDR_W-1:0] hdr);
    return make_request(hdr[ADDR_W +: ADDR_W] == ADDR_W'(LOCAL_X),
                        hdr[0 +: ADDR_W]      == ADDR_W'(LOCAL_Y));
  endfunction

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          bundle_d = route_of(head_flit[HDR_LSB +: HDR_W]);
          state_d  = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (grant && bundle_q[REQ_BIT]) begin
          pop = 1'b1;
          // a second buffered flit keeps the request up for back-to-back grants
          if (count > CNT_W'(1)) begin
            bundle_d = route_of(next_hdr);
          end else begin
            bundle_d = RB_NULL;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        bundle_d = RB_NULL;
        state_d  = ST_IDLE;
      end
    endcase
    credit_d   = pop;
    overflow_d = overflow_q | push_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bundle_q   <= RB_NULL;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bundle_q   <= bundle_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign request_bundle = bundle_q;
  assign credit_out     = credit_q;
  assign overflow       = overflow_q;
  assign out_flit       = head_flit;

`ifdef REQUESTER_STARVE_MON_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_q, starve_d;

  always_comb begin
    starve_cnt_d = '0;
    if (state_q == ST_REQUEST && !grant) begin
      starve_cnt_d = starve_cnt_q;
      if (starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SW'(1);
    end
    starve_d = starve_q | (starve_cnt_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule
